// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared constants for the TRNG sampling controller
package trng_pkg;

    localparam int WORD_W = 32;

    localparam int DEF_SAMPLE_DIV = 4096;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RCT_CUTOFF = 32;
    localparam int DEF_APT_WINDOW = 512;
    localparam int DEF_APT_CUTOFF = 400;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_PUSH    = 3'd2;
    localparam logic [2:0] ST_STALL   = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;

endpackage

// File: rtl/trng_health_test.sv
// rtl/trng_health_test.sv - repetition-count and adaptive-proportion health tests
module trng_health_test
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW = DEF_APT_WINDOW,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    input  logic strobe,
    input  logic clear,
    output logic fail
);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(APT_CUTOFF + 1);
    localparam int IW = $clog2(APT_WINDOW);

    logic          seen_q, seen_d;
    logic          prev_q, prev_d;
    logic [RW-1:0] rct_q, rct_d;
    logic          ref_q, ref_d;
    logic [AW-1:0] apt_q, apt_d;
    logic [IW-1:0] idx_q, idx_d;

    // Counter update on each sample strobe; counters saturate at their cutoff
    always_comb begin
        seen_d = seen_q;
        prev_d = prev_q;
        rct_d  = rct_q;
        ref_d  = ref_q;
        apt_d  = apt_q;
        idx_d  = idx_q;
        if (strobe) begin
            seen_d = 1'b1;
            prev_d = sample;
            if (!seen_q || (sample != prev_q)) begin
                rct_d = RW'(1);
            end else if (rct_q != RW'(RCT_CUTOFF)) begin
                rct_d = rct_q + 1'b1;
            end
            if (idx_q == '0) begin
                ref_d = sample;
                apt_d = AW'(1);
            end else if ((sample == ref_q) && (apt_q != AW'(APT_CUTOFF))) begin
                apt_d = apt_q + 1'b1;
            end
            idx_d = idx_q + 1'b1;
        end
        if (clear) begin
            seen_d = 1'b0;
            prev_d = 1'b0;
            rct_d  = '0;
            ref_d  = 1'b0;
            apt_d  = '0;
            idx_d  = '0;
        end
        fail = strobe && ((rct_d == RW'(RCT_CUTOFF)) || (apt_d == AW'(APT_CUTOFF)));
    end

    // Health counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q <= 1'b0;
            prev_q <= 1'b0;
            rct_q  <= '0;
            ref_q  <= 1'b0;
            apt_q  <= '0;
            idx_q  <= '0;
        end else begin
            seen_q <= seen_d;
            prev_q <= prev_d;
            rct_q  <= rct_d;
            ref_q  <= ref_d;
            apt_q  <= apt_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/trng_sampler_ctrl.sv
// rtl/trng_sampler_ctrl.sv - entropy sampling sequencer with health tests and word FIFO
module trng_sampler_ctrl
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW = DEF_APT_WINDOW,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          raw_bit,
    input  logic                          enable,
    input  logic                          rd_req,
    output logic                          rd_ack,
    output logic [WORD_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          health_fail,
    input  logic                          clear_fail
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(WORD_W);

    logic [2:0]        state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [BW-1:0]     bit_ctr_q, bit_ctr_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_ack_q, rd_ack_d, rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;

    logic strobe, pop, push, health_clear, health_hit, flush;

    trng_health_test #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sync2_q),
        .strobe  (strobe),
        .clear   (health_clear),
        .fail    (health_hit)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; a health failure outranks completing a word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable) state_d = ST_COLLECT;
            ST_COLLECT: begin
                if (!enable)                                      state_d = ST_IDLE;
                else if (health_hit)                             state_d = ST_FAIL;
                else if (strobe && bit_ctr_q == BW'(WORD_W - 1))  state_d = ST_PUSH;
            end
            ST_PUSH:    state_d = push ? ST_COLLECT : ST_STALL;
            ST_STALL:   if (push) state_d = ST_COLLECT;
            ST_FAIL:    if (clear_fail) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: sample strobe, FIFO pop/push qualifiers, health clear
    always_comb begin
        strobe       = (state_q == ST_COLLECT) && enable && (timer_q == TW'(SAMPLE_DIV - 1));
        pop          = rd_req && (count_q != '0) && (state_q != ST_FAIL);
        push         = ((state_q == ST_PUSH) || (state_q == ST_STALL)) &&
                       ((count_q != CW'(FIFO_DEPTH)) || pop);
        health_clear = (state_q == ST_FAIL) && clear_fail;
    end

    // Synchronizer, sample timer and word accumulator
    always_comb begin
        flush     = (state_d == ST_FAIL);
        sync1_d   = raw_bit;
        sync2_d   = sync1_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        bit_ctr_d = bit_ctr_q;
        if ((state_q == ST_COLLECT) && enable) begin
            timer_d = strobe ? '0 : timer_q + 1'b1;
        end
        if (health_clear) timer_d = '0;
        if (flush) begin
            acc_d     = '0;
            bit_ctr_d = '0;
        end else if (strobe) begin
            acc_d     = {acc_q[WORD_W-2:0], sync2_q};
            bit_ctr_d = bit_ctr_q + 1'b1;
        end else if (push) begin
            bit_ctr_d = '0;
        end
    end

    // Word FIFO and registered read response
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_ack_d   = rd_req;
        rd_valid_d = pop;
        rd_data_d  = pop ? mem_q[rd_ptr_q] : '0;
        if (push) begin
            mem_d[wr_ptr_q] = acc_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Datapath and FIFO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            timer_q    <= '0;
            acc_q      <= '0;
            bit_ctr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            bit_ctr_q  <= bit_ctr_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_ack_q   <= rd_ack_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_ack      = rd_ack_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign ready       = (count_q != '0);
    assign fill_level  = count_q;
    assign health_fail = (state_q == ST_FAIL);

endmodule

// File: tb/tb_trng_sampler_ctrl.sv
// tb/tb_trng_sampler_ctrl.sv - scoreboard bench for trng_sampler_ctrl
module tb_trng_sampler_ctrl;
    import trng_pkg::*;

    localparam int SDIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        raw_bit = 1'b0;
    logic        enable = 1'b0;
    logic        rd_req = 1'b0;
    logic        clear_fail = 1'b0;
    logic        rd_ack, rd_valid, ready, health_fail;
    logic [31:0] rd_data;
    logic [2:0]  fill_level;
    logic        a_rd_ack, a_rd_valid, a_ready, a_health_fail;
    logic [31:0] a_rd_data;
    logic [2:0]  a_fill_level;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    trng_sampler_ctrl #(.SAMPLE_DIV(SDIV), .FIFO_DEPTH(4), .RCT_CUTOFF(32),
                        .APT_WINDOW(512), .APT_CUTOFF(400)) dut (
        .clk(clk), .reset_n(reset_n), .raw_bit(raw_bit), .enable(enable),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .ready(ready), .fill_level(fill_level), .health_fail(health_fail),
        .clear_fail(clear_fail));

    trng_sampler_ctrl #(.SAMPLE_DIV(SDIV), .FIFO_DEPTH(4), .RCT_CUTOFF(32),
                        .APT_WINDOW(16), .APT_CUTOFF(13)) dut_apt (
        .clk(clk), .reset_n(reset_n), .raw_bit(raw_bit), .enable(enable),
        .rd_req(rd_req), .rd_ack(a_rd_ack), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .ready(a_ready), .fill_level(a_fill_level), .health_fail(a_health_fail),
        .clear_fail(clear_fail));

    task automatic apply_reset();
        reset_n = 1'b0; enable = 1'b0; rd_req = 1'b0; clear_fail = 1'b0; raw_bit = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_collect();
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    // One sample per SDIV cycles, MSB first; a full word also waits out the PUSH cycle
    task automatic drive_bits(input logic [31:0] w, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            raw_bit = w[31 - (first + i)];
            repeat (SDIV) @(posedge clk);
            #1;
        end
        if (first + n == 32) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_read();
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (fill_level !== 3'd0) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL reset_health: got %b want 0", health_fail); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        apply_reset();
    endtask

    task automatic test_empty_read();
        apply_reset();
        pulse_read();
        n_cmp++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL empty_ack: got %b want 1", rd_ack); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL empty_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL empty_data: got %h want 0", rd_data); end
        @(posedge clk); #1;
        n_cmp++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL ack_one_cycle: got %b want 0", rd_ack); end
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h5555_5555;
        apply_reset();
        start_collect();
        exp_q.push_back(w);
        drive_bits(w, 0, 31);
        raw_bit = w[0];
        repeat (SDIV) @(posedge clk);
        #1;
        n_cmp++; if (fill_level !== 3'd0) begin n_bad++; $display("FAIL pre_push_fill: got %0d want 0", fill_level); end
        @(posedge clk); #1;
        enable = 1'b0;
        n_cmp++; if (fill_level !== 3'd1) begin n_bad++; $display("FAIL push_fill: got %0d want 1", fill_level); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL push_ready: got %b want 1", ready); end
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL word_ack: got %b want 1", rd_ack); end
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL word_valid: got %b want 1", rd_valid); end
        n_cmp++; if (rd_data !== e) begin n_bad++; $display("FAIL word_data: got %h want %h", rd_data, e); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL post_pop_ready: got %b want 0", ready); end
    endtask

    task automatic test_rct();
        apply_reset();
        start_collect();
        drive_bits(32'hFFFF_FFFF, 0, 31);
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL rct_31: got %b want 0", health_fail); end
        raw_bit = 1'b1;
        repeat (SDIV) @(posedge clk);
        #1;
        n_cmp++; if (health_fail !== 1'b1) begin n_bad++; $display("FAIL rct_32: got %b want 1", health_fail); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rct_ready: got %b want 0", ready); end
        n_cmp++; if (fill_level !== 3'd0) begin n_bad++; $display("FAIL rct_fill: got %0d want 0", fill_level); end
        pulse_read();
        n_cmp++; if (rd_ack !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL fail_read: ack %b valid %b want 1 0", rd_ack, rd_valid); end
        enable = 1'b0;
        clear_fail = 1'b1;
        @(posedge clk); #1;
        clear_fail = 1'b0;
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL clear: got %b want 0", health_fail); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL clear_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        start_collect();
        exp_q.push_back(32'hAAAA_AAAA);
        drive_bits(32'hAAAA_AAAA, 0, 32);
        enable = 1'b0;
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL rct_after_clear: got %b want 0", health_fail); end
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_bad++; $display("FAIL clear_word: valid %b data %h want 1 %h", rd_valid, rd_data, e); end
    endtask

    task automatic test_stall_back_to_back();
        logic [31:0] words [5];
        words = '{32'h5555_5555, 32'h3C3C_3C3C, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0F0F_0F0F};
        apply_reset();
        start_collect();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(words[i]);
            drive_bits(words[i], 0, 32);
        end
        n_cmp++; if (fill_level !== 3'd4) begin n_bad++; $display("FAIL full_fill: got %0d want 4", fill_level); end
        exp_q.push_back(words[4]);
        drive_bits(words[4], 0, 32);
        enable = 1'b0;
        n_cmp++; if (dut.state_q !== ST_STALL) begin n_bad++; $display("FAIL stall_state: got %0d want %0d", dut.state_q, ST_STALL); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (dut.state_q !== ST_STALL || fill_level !== 3'd4) begin n_bad++; $display("FAIL stall_hold: state %0d fill %0d want %0d 4", dut.state_q, fill_level, ST_STALL); end
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_bad++; $display("FAIL stall_pop: valid %b data %h want 1 %h", rd_valid, rd_data, e); end
        n_cmp++; if (fill_level !== 3'd4) begin n_bad++; $display("FAIL stall_push_fill: got %0d want 4", fill_level); end
        rd_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 4) rd_req = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (rd_ack !== 1'b1 || rd_valid !== 1'b1 || rd_data !== e) begin n_bad++; $display("FAIL b2b_%0d: ack %b valid %b data %h want 1 1 %h", k, rd_ack, rd_valid, rd_data, e); end
            end else begin
                n_cmp++; if (rd_ack !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin n_bad++; $display("FAIL b2b_empty: ack %b valid %b data %h want 1 0 0", rd_ack, rd_valid, rd_data); end
            end
        end
        n_cmp++; if (fill_level !== 3'd0) begin n_bad++; $display("FAIL drained_fill: got %0d want 0", fill_level); end
    endtask

    task automatic test_apt();
        apply_reset();
        start_collect();
        drive_bits(32'hFFF8_0000, 0, 12);
        n_cmp++; if (a_health_fail !== 1'b0) begin n_bad++; $display("FAIL apt_12: got %b want 0", a_health_fail); end
        drive_bits(32'hFFF8_0000, 12, 4);
        n_cmp++; if (a_health_fail !== 1'b1) begin n_bad++; $display("FAIL apt_13: got %b want 1", a_health_fail); end
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL apt_big_window: got %b want 0", health_fail); end
        apply_reset();
        start_collect();
        exp_q.push_back(32'hFFF0_FFF0);
        drive_bits(32'hFFF0_FFF0, 0, 32);
        enable = 1'b0;
        n_cmp++; if (a_health_fail !== 1'b0) begin n_bad++; $display("FAIL apt_restart: got %b want 0", a_health_fail); end
        n_cmp++; if (a_fill_level !== 3'd1) begin n_bad++; $display("FAIL apt_fill: got %0d want 1", a_fill_level); end
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (a_rd_valid !== 1'b1 || a_rd_data !== e) begin n_bad++; $display("FAIL apt_word: valid %b data %h want 1 %h", a_rd_valid, a_rd_data, e); end
    endtask

    task automatic test_enable_pause();
        logic [31:0] w;
        w = 32'hC3A5_96E1;
        apply_reset();
        start_collect();
        exp_q.push_back(w);
        drive_bits(w, 0, 10);
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            raw_bit = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1;
        n_cmp++; if (dut.state_q !== ST_IDLE || fill_level !== 3'd0) begin n_bad++; $display("FAIL pause: state %0d fill %0d want %0d 0", dut.state_q, fill_level, ST_IDLE); end
        start_collect();
        drive_bits(w, 10, 22);
        enable = 1'b0;
        n_cmp++; if (fill_level !== 3'd1) begin n_bad++; $display("FAIL pause_fill: got %0d want 1", fill_level); end
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_bad++; $display("FAIL pause_word: valid %b data %h want 1 %h", rd_valid, rd_data, e); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start_collect();
        exp_q.push_back(32'h600D_F00D);
        drive_bits(32'h600D_F00D, 0, 32);
        exp_q.push_back(32'hFEED_0A0A);
        drive_bits(32'hFEED_0A0A, 0, 32);
        drive_bits(32'hDEAD_BEEF, 0, 5);
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_bad++; $display("FAIL pre_reset_word: valid %b data %h want 1 %h", rd_valid, rd_data, e); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL pre_reset_ready: got %b want 1", ready); end
        #2 reset_n = 1'b0;
        enable = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++; if (rd_ack !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin n_bad++; $display("FAIL async_rd: ack %b valid %b data %h want 0 0 0", rd_ack, rd_valid, rd_data); end
        n_cmp++; if (ready !== 1'b0 || fill_level !== 3'd0 || health_fail !== 1'b0) begin n_bad++; $display("FAIL async_status: ready %b fill %0d fail %b want 0 0 0", ready, fill_level, health_fail); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        start_collect();
        exp_q.push_back(32'h1357_9BDF);
        drive_bits(32'h1357_9BDF, 0, 32);
        enable = 1'b0;
        n_cmp++; if (fill_level !== 3'd1) begin n_bad++; $display("FAIL post_reset_fill: got %0d want 1", fill_level); end
        pulse_read();
        e = exp_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== e) begin n_bad++; $display("FAIL post_reset_word: valid %b data %h want 1 %h", rd_valid, rd_data, e); end
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_single_word();
        test_rct();
        test_stall_back_to_back();
        test_apt();
        test_enable_pause();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trng_sampler_ctrl.md
Name: trng_sampler_ctrl

Overview:
Sequencing controller for the ring-oscillator entropy source. It paces sampling of the XOR-combined oscillator bit and runs continuous health tests (repetition count and adaptive proportion). Healthy samples are packed into 32-bit words and buffered in a small FIFO. The block sits between the free-running oscillator array and the TRNG register interface, which pops words through a req/ack handshake.

Parameters:
SAMPLE_DIV, 4096, clk cycles between samples (>=2)
FIFO_DEPTH, 4, word FIFO depth (power of 2, 2..16)
RCT_CUTOFF, 32, consecutive identical samples that trigger a repetition-count failure
APT_WINDOW, 512, samples per adaptive-proportion window (power of 2)
APT_CUTOFF, 400, matches to the window's first bit that trigger a proportion failure

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
raw_bit  in  1  asynchronous entropy bit (XOR of oscillators)
enable  in  1  level; 1 = sampling runs
rd_req  in  1  single-cycle pop request
rd_ack  out  1  one-cycle pulse, the cycle after rd_req
rd_data  out  32  popped word, valid with rd_ack
rd_valid  out  1  valid with rd_ack; 1 = word popped, 0 = FIFO was empty
ready  out  1  FIFO non-empty
fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
health_fail  out  1  sticky failure flag
clear_fail  in  1  single-cycle pulse; leaves FAIL state

Behaviour:
- Reset is asynchronous, active-low, one clock; every register is reset. All outputs reset to 0, and state is IDLE.
- raw_bit passes through a 2-flop synchronizer; the sampled value is the second flop.
- Sample timer counts 0..SAMPLE_DIV-1 while state is COLLECT. The strobe fires at SAMPLE_DIV-1 and the counter wraps to 0. The timer holds in every other state.
- On a strobe:
  - the sample shifts into acc[0] (acc shifts left);
  - bit_ctr increments, 0..31;
  - RCT and APT update in the same cycle.
- FSM states: IDLE, COLLECT, PUSH, STALL, FAIL.
  - IDLE: the cycle enable=1 -> COLLECT.
  - COLLECT: enable=0 -> IDLE; the timer, acc, bit_ctr and health counters hold, so the partial word is kept. A strobe with bit_ctr==31 and no health failure -> PUSH. A health failure -> FAIL, with priority over PUSH.
  - PUSH: one cycle. If the FIFO is not full, or a pop happens in the same cycle, write acc, clear bit_ctr, -> COLLECT. Otherwise -> STALL.
  - STALL: wait with the timer frozen. The cycle the FIFO has space (including a pop in that cycle), push -> COLLECT.
  - FAIL: health_fail=1, FIFO flushed (ready=0, fill_level=0), acc and bit_ctr cleared. clear_fail -> IDLE with RCT/APT counters and timer cleared and health_fail deasserted next cycle. Any clear_fail outside FAIL is ignored.
- RCT:
  - count resets to 1 when the sample differs from the previous sample, else increments;
  - failure when the count reaches RCT_CUTOFF;
  - the first sample after reset or clear sets count=1.
- APT:
  - the first sample of a window is the reference, with match count=1;
  - each later sample equal to the reference increments the count;
  - failure when the count reaches APT_CUTOFF;
  - the window restarts after APT_WINDOW samples.
- Read handshake:
  - rd_req in cycle N gives rd_ack=1 in N+1.
  - If the FIFO was non-empty at N: rd_data=head, rd_valid=1, pop at the N edge.
  - Otherwise: rd_data=0, rd_valid=0.
  - rd_data is 0 whenever rd_ack=0.
  - rd_req during FAIL returns rd_valid=0.
  - Back-to-back rd_req every cycle is legal.
- FIFO pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves fill_level unchanged. fill_level never exceeds FIFO_DEPTH.
- Reset mid-word or mid-STALL discards everything; there is no partial-state retention.

Decomposition:
- Shared package trng_pkg holds:
  - FSM state encodings (3-bit localparams);
  - default values of SAMPLE_DIV, RCT_CUTOFF, APT_WINDOW, APT_CUTOFF;
  - the word width of 32.
- One natural sub-module, trng_health_test, contains the RCT and APT counters. Its interface is sample, strobe, clear in and fail out.
- The FIFO stays inline, since it is small.

Test Plan:
- SAMPLE_DIV=4, alternating raw_bit 0,1,0,1..., enable=1 -> first push after 4*32 cycles plus sync; ready=1, fill_level=1; rd_req gives rd_ack next cycle with rd_data=32'h55555555, rd_valid=1.
- Constant raw_bit=1, RCT_CUTOFF=32 -> health_fail=1 on the 32nd strobe, no word pushed, ready=0. clear_fail returns to IDLE with health_fail=0 the next cycle.
- FIFO_DEPTH=4, no reads, alternating input -> fill_level reaches 4, state STALL, timer frozen. A single pop gives rd_valid=1 and the stalled word is pushed the same cycle, so fill_level stays 4.
- rd_req with an empty FIFO -> rd_ack=1, rd_valid=0, rd_data=0. Back-to-back rd_req with 2 words stored -> two valid words in order, third rd_valid=0.
- APT_WINDOW=16, APT_CUTOFF=13, pattern of 13 ones in 16 -> fail; pattern of 12 ones -> no fail, window restarts.
- Drop enable at bit_ctr=10, hold 100 cycles, re-enable -> the word completes after 22 more strobes with the earlier bits preserved. Asserting reset_n=0 asynchronously mid-word -> all outputs 0 immediately.
